i2c_master_wr: RTL and testbench
================================

I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period (legal values >= 2).
REQ-002 SHALL have parameter MAX_BYTES, default 4, meaning the maximum number of data bytes per transaction (legal values >= 1).
REQ-003 SHALL have derived parameter LEN_W = clog2(MAX_BYTES+1), meaning the width of len.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  transaction request, sampled only in IDLE.
REQ-007 addr  input  7  slave address; the R/W bit is always 0 (write).
REQ-008 data  input  8*MAX_BYTES  payload; byte k = data[8k+7:8k].
REQ-009 len  input  LEN_W  number of data bytes to send (0 = address-only transaction).
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of a transaction.
REQ-012 nack  output  1  valid with done; 1 = a slave NACK aborted the transaction.
REQ-013 scl_oe  output  1  open-drain SCL pull-down (1 = drive low).
REQ-014 sda_oe  output  1  open-drain SDA pull-down (1 = drive low).
REQ-015 scl_i  input  1  sensed SCL line level.
REQ-016 sda_i  input  1  sensed SDA line level.

Function
REQ-017 SHALL implement states IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
- IDLE -> START on start.
- START -> ADDR.
- ADDR -> ACK_A after 8 bits.
- ACK_A -> STOP on NACK or len_latched == 0; otherwise ACK_A -> DATA.
- DATA -> ACK_D after 8 bits.
- ACK_D -> STOP on NACK or last byte; otherwise ACK_D -> DATA (next byte).
- STOP -> IDLE.
REQ-018 SHALL latch addr, data, and min(len, MAX_BYTES) on the clock edge that accepts start; later input changes SHALL NOT affect the transaction.
REQ-019 SHALL ignore start while busy == 1.
REQ-020 SHALL hold the quarter-tick prescaler at 0 in IDLE, count 0..CLK_DIV-1 otherwise, and advance quarter q (0..3) when the prescaler wraps.
REQ-021 Each bit SHALL occupy 4 quarters: scl_oe = 1 in q0–q1 and scl_oe = 0 in q2–q3; sda_oe SHALL change only at the start of q0.
REQ-022 START SHALL drive scl_oe = 0 throughout, with sda_oe = 0 in q0–q1 and sda_oe = 1 in q2–q3.
REQ-023 STOP SHALL drive sda_oe = 1 in q0–q1 and sda_oe = 0 in q2–q3, with scl_oe = 1 in q0 and scl_oe = 0 in q1–q3.
REQ-024 ADDR SHALL shift out {addr, 1'b0} MSB first; DATA SHALL send bytes 0..n-1 in order, each MSB first; sda_oe = ~bit.
REQ-025 ACK states SHALL set sda_oe = 0 (release SDA) and sample sda_i on the final clk of q2; a sampled 1 is a NACK.
REQ-026 Clock stretching: while scl_oe = 0 and scl_i = 0 during q2 or q3, the prescaler SHALL freeze.
REQ-027 busy SHALL rise on the clock edge after start is accepted and fall together with the done pulse.
REQ-028 done SHALL pulse for exactly one cycle on the STOP -> IDLE transition; nack SHALL hold its value until the next accepted start.
REQ-029 With no stretching, a transaction SHALL last (2 + 9*(1+n)) * 4 * CLK_DIV clk cycles from start acceptance to done.
REQ-030 A start asserted on the same cycle as done SHALL be ignored; a start held high on the following cycle SHALL be accepted.

Reset
REQ-031 SHALL, asynchronously on rst = 1, force state IDLE, prescaler 0, q 0, bit counter 0, byte counter 0, busy 0, done 0, nack 0, scl_oe 0, sda_oe 0.
REQ-032 rst asserted mid-transaction SHALL abort immediately with both lines released, and SHALL NOT produce a done pulse.

Verification
REQ-033 CLK_DIV = 2, addr = 7'h50, len = 1, data byte 0 = 8'hA5, slave ACKs both bytes -> SDA bit sequence 1010_0000, A, 1010_0101, A; done after 160 clk; nack = 0.
REQ-034 len = 0, slave ACKs -> address-only transaction; done after 88 clk at CLK_DIV = 2; nack = 0.
REQ-035 Slave NACKs the address (sda_i = 1) with len = 3 -> no DATA bits sent; STOP follows; done with nack = 1.
REQ-036 len = 3, slave NACKs byte 1 -> byte 2 not sent; nack = 1.
REQ-037 Slave holds scl_i = 0 for 10 clk in a data bit -> done delayed by exactly 10 clk.
REQ-038 rst asserted during DATA -> scl_oe = sda_oe = 0 immediately, no done pulse, and the next start runs normally.

Source files
------------

// File: rtl/i2c_master_wr_if.sv
// Command/status and open-drain line bundle between the I2C write master and its user.
interface i2c_master_wr_if #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) ();
  logic                   start;
  logic [6:0]             addr;
  logic [8*MAX_BYTES-1:0] data;
  logic [LEN_W-1:0]       len;
  logic                   busy;
  logic                   done;
  logic                   nack;
  logic                   scl_oe;
  logic                   sda_oe;
  logic                   scl_i;
  logic                   sda_i;

  modport master (
    input  start, addr, data, len, scl_i, sda_i,
    output busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, data, len, scl_i, sda_i,
    input  busy, done, nack, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_wr.sv
// I2C write-only master: START, address+W, up to MAX_BYTES data bytes, STOP.
// Each bit is four prescaled quarters; the slave may stretch SCL in the high half.
module i2c_master_wr #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  i2c_master_wr_if.master bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          presc_reg;
  logic [1:0]             q_reg;
  logic [2:0]             bit_cnt_reg;
  logic [LEN_W-1:0]       byte_cnt_reg;
  logic [LEN_W-1:0]       len_reg;
  logic [7:0]             shift_reg;
  logic [8*MAX_BYTES-1:0] data_reg;
  logic                   nack_reg;
  logic                   done_reg;
  logic                   scl_oe, sda_oe;
  logic                   stall, tick, bit_end, last_bit, accept;

  // The slave holding SCL low after we released it freezes the quarter timer.
  assign stall    = q_reg[1] && !scl_oe && !bus.scl_i;
  assign tick     = (presc_reg == PRESC_LAST) && !stall;
  assign bit_end  = tick && (q_reg == 2'd3);
  assign last_bit = (bit_cnt_reg == 3'd7);
  // done_reg blocks a start arriving in the very cycle the previous transfer reports.
  assign accept   = (state_reg == IDLE) && bus.start && !done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    unique case (state_reg)
      IDLE:  if (accept) state_next = START;
      START: begin
        sda_oe = q_reg[1];
        if (bit_end) state_next = ADDR;
      end
      ADDR: begin
        scl_oe = !q_reg[1];
        sda_oe = !shift_reg[7];
        if (bit_end && last_bit) state_next = ACK_A;
      end
      ACK_A: begin
        scl_oe = !q_reg[1];
        if (bit_end) state_next = (nack_reg || len_reg == '0) ? STOP : DATA;
      end
      DATA: begin
        scl_oe = !q_reg[1];
        sda_oe = !shift_reg[7];
        if (bit_end && last_bit) state_next = ACK_D;
      end
      ACK_D: begin
        scl_oe = !q_reg[1];
        if (bit_end) state_next = (nack_reg || byte_cnt_reg == len_reg) ? STOP : DATA;
      end
      STOP: begin
        scl_oe = (q_reg == 2'd0);
        sda_oe = !q_reg[1];
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg    <= '0;
      q_reg        <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      len_reg      <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      nack_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        presc_reg <= '0;
        q_reg     <= '0;
        if (accept) begin
          shift_reg    <= {bus.addr, 1'b0};
          data_reg     <= bus.data;
          len_reg      <= (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
          bit_cnt_reg  <= '0;
          byte_cnt_reg <= '0;
          nack_reg     <= 1'b0;
        end
      end else if (!stall) begin
        presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
        if (tick) q_reg <= q_reg + 2'd1;
        if ((state_reg == ACK_A || state_reg == ACK_D) && tick && q_reg == 2'd2 && bus.sda_i)
          nack_reg <= 1'b1;
        if (bit_end) begin
          case (state_reg)
            ADDR, DATA: begin
              shift_reg   <= {shift_reg[6:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (state_reg == DATA && last_bit) byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
            // Payload is consumed from the low byte upward.
            ACK_A, ACK_D: if (state_next == DATA) begin
              shift_reg <= data_reg[7:0];
              data_reg  <= data_reg >> 8;
            end
            STOP:    done_reg <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;
  assign bus.nack   = nack_reg;
  assign bus.scl_oe = scl_oe;
  assign bus.sda_oe = sda_oe;
endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: a bus-level slave decodes SCL/SDA and answers ACK/NACK;
// each transfer is compared with bit counts, bytes and durations derived from the protocol.
module tb_i2c_master_wr;
  localparam int CD = 2;
  localparam int MB = 4;
  localparam int LW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_wr_if #(.MAX_BYTES(MB), .LEN_W(LW)) bus ();

  logic stretch    = 1'b0;
  logic slave_pull = 1'b0;
  assign bus.scl_i = ~bus.scl_oe & ~stretch;
  assign bus.sda_i = ~bus.sda_oe & ~slave_pull;

  i2c_master_wr #(.CLK_DIV(CD), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   passes = 0;
  int   fails  = 0;
  int   checks = 0;
  bit   ack_plan [0:MB];
  bit   bits_q [$];
  int   stop_cnt = 0;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;

  // Slave: START clears the bit log, SCL rise records SDA, and after the
  // eighth bit of a group it pulls SDA low for the ACK slot if planned.
  always @(negedge clk) begin
    if (rst) begin
      bits_q.delete();
      slave_pull = 1'b0;
      scl_prev   = 1'b1;
      sda_prev   = 1'b1;
    end else begin
      if (scl_prev && bus.scl_i && sda_prev && !bus.sda_i) bits_q.delete();
      if (scl_prev && bus.scl_i && !sda_prev && bus.sda_i) stop_cnt++;
      if (!scl_prev && bus.scl_i) bits_q.push_back(bus.sda_i);
      if (scl_prev && !bus.scl_i) begin
        if (bits_q.size() % 9 == 8 && bits_q.size() / 9 <= MB) slave_pull = ack_plan[bits_q.size() / 9];
        else slave_pull = 1'b0;
      end
      scl_prev = bus.scl_i;
      sda_prev = bus.sda_i;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_acks(input int nack_at);
    for (int i = 0; i <= MB; i++) ack_plan[i] = (i != nack_at);
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(input bit stretch_en, output int cnt, output bit busy_ok);
    int s_at;
    s_at    = 10 * 4 * CD + 2 * CD;  // first data bit, start of its SCL-high half
    cnt     = 0;
    busy_ok = 1'b1;
    while (!bus.done && cnt < 4000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (stretch_en && cnt == s_at) stretch = 1'b1;
      if (stretch_en && cnt == s_at + 10) stretch = 1'b0;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_txn(input string name, input logic [6:0] a, input logic [8*MB-1:0] d,
                         input logic [LW-1:0] l, input bit stretch_en, input bit hold_start);
    int n, groups, exp_cycles, cnt;
    bit exp_nack, busy_ok;
    logic [8:0] got, want;
    n        = (l > MB) ? MB : int'(l);
    exp_nack = !ack_plan[0];
    groups   = 1;
    for (int k = 0; k < n && !exp_nack; k++) begin
      groups++;
      if (!ack_plan[k + 1]) exp_nack = 1'b1;
    end
    exp_cycles = (2 + 9 * groups) * 4 * CD + (stretch_en ? 10 : 0);
    stop_cnt   = 0;

    bus.addr  = a;
    bus.data  = d;
    bus.len   = l;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, " busy_rise"}, bus.busy, 1);
    if (!hold_start) begin
      bus.start = 1'b0;
      bus.addr  = 7'($urandom);
      bus.data  = (8*MB)'($urandom);
      bus.len   = LW'($urandom);
    end
    wait_done(stretch_en, cnt, busy_ok);
    chk({name, " done_latency"}, cnt, exp_cycles);
    chk({name, " busy_held"}, busy_ok, 1);
    chk({name, " busy_fall"}, bus.busy, 0);
    chk({name, " nack"}, bus.nack, exp_nack);
    $display("txn %s addr=%h len=%0d groups=%0d cycles=%0d nack=%0b", name, a, l, groups, cnt, bus.nack);
    if (!hold_start) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, " done_width"}, bus.done, 0);
      chk({name, " nack_hold"}, bus.nack, exp_nack);
      chk({name, " stop_seen"}, stop_cnt, 1);
      chk({name, " bit_count"}, bits_q.size(), 9 * groups + 1);
      if (bits_q.size() == 9 * groups + 1) begin
        for (int j = 0; j < groups; j++) begin
          for (int b = 0; b < 9; b++) got[8 - b] = bits_q[9 * j + b];
          want = (j == 0) ? {a, 1'b0, !ack_plan[0]} : {d[8*(j-1) +: 8], !ack_plan[j]};
          chk($sformatf("%s byte%0d+ack", name, j), got, want);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  busy_ok, done_seen;
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    bus.len   = '0;
    set_acks(-1);
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset nack", bus.nack, 0);
    chk("reset scl_oe", bus.scl_oe, 0);
    chk("reset sda_oe", bus.sda_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_acks(-1);
    run_txn("one_byte", 7'h50, 32'h0000_00A5, 3'd1, 1'b0, 1'b0);
    run_txn("addr_only", 7'h50, 32'h1234_5678, 3'd0, 1'b0, 1'b0);
    set_acks(0);
    run_txn("addr_nack", 7'h21, 32'hCAFE_F00D, 3'd3, 1'b0, 1'b0);
    set_acks(2);
    run_txn("byte1_nack", 7'h3B, 32'h0033_2211, 3'd3, 1'b0, 1'b0);
    set_acks(-1);
    run_txn("stretch", 7'h11, 32'h0000_005A, 3'd1, 1'b1, 1'b0);
    run_txn("len_clamp", 7'h7F, 32'h8001_FF00, 3'd7, 1'b0, 1'b0);

    // Reset in the middle of the first data bit aborts without done.
    bus.addr  = 7'h2A;
    bus.data  = 32'h0000_003C;
    bus.len   = 3'd2;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10 * 4 * CD + 1) @(negedge clk);
    chk("rst_mid pre scl_oe", bus.scl_oe, 1);
    chk("rst_mid pre sda_oe", bus.sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid scl_oe", bus.scl_oe, 0);
    chk("rst_mid sda_oe", bus.sda_oe, 0);
    chk("rst_mid busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    chk("rst_mid no_done", done_seen, 0);
    chk("rst_mid nack", bus.nack, 0);
    run_txn("after_rst", 7'h2A, 32'h0000_C33C, 3'd2, 1'b0, 1'b0);

    // start held high: ignored in the done cycle, accepted on the next one.
    set_acks(-1);
    run_txn("b2b_first", 7'h44, 32'h0000_0099, 3'd1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b ignored_in_done_cycle", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b accepted_next", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(1'b0, cnt, busy_ok);
    chk("b2b second latency", cnt, (2 + 9 * 2) * 4 * CD);
    chk("b2b second nack", bus.nack, 0);
    $display("txn b2b_second cycles=%0d nack=%0b", cnt, bus.nack);
    @(negedge clk);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i <= MB; i++) ack_plan[i] = ($urandom_range(0, 9) != 0);
      run_txn($sformatf("rand%0d", t), 7'($urandom), (8*MB)'($urandom),
              LW'($urandom_range(0, 7)), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
